// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// clk_div_gen : NUM_CH independent 50%-duty clock dividers with rising-edge
//               tick strobes. Define CLK_DIV_SYNC_LOAD_EN for phase-aligning LOAD.
// Revision    : 1.0
// ============================================================================
module clk_div_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_load,
  output logic [NUM_CH-1:0]       o_clk_out,
  output logic [NUM_CH-1:0]       o_tick
);

  localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

  logic w_sync;

`ifdef CLK_DIV_SYNC_LOAD_EN
  assign w_sync = i_load;
`else
  assign w_sync = 1'b0;
`endif

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_cur_div;
      logic [DIV_W-1:0] r_shadow;
      logic             r_out;
      logic             r_tick;
      logic [DIV_W-1:0] w_div_in;
      logic [DIV_W-1:0] w_half;
      logic [DIV_W-1:0] w_next_div;
      logic             w_boundary;

      assign w_div_in   = i_div[ch*DIV_W +: DIV_W];
      // A programmed half-period of zero runs as the fastest legal rate.
      assign w_half     = (r_cur_div == '0) ? c_one : r_cur_div;
      assign w_boundary = (r_cnt == (w_half - c_one));
      assign w_next_div = i_load ? w_div_in : r_shadow;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_cnt     <= '0;
          r_cur_div <= c_one;
          r_shadow  <= c_one;
          r_out     <= 1'b1;
          r_tick    <= 1'b0;
        end else begin
          if (i_load) begin
            r_shadow <= w_div_in;
          end

          if (w_sync) begin
            r_cnt     <= '0;
            r_out     <= 1'b1;
            r_tick    <= 1'b0;
            r_cur_div <= w_div_in;
          end else if (!i_en[ch]) begin
            r_cnt  <= '0;
            r_out  <= 1'b1;
            r_tick <= 1'b0;
          end else if (w_boundary) begin
            // New divisor is adopted only here, so every phase is whole.
            r_cnt     <= '0;
            r_out     <= ~r_out;
            r_tick    <= ~r_out;
            r_cur_div <= w_next_div;
          end else begin
            r_cnt  <= r_cnt + c_one;
            r_tick <= 1'b0;
          end
        end
      end

      assign o_clk_out[ch] = r_out;
      assign o_tick[ch]    = r_tick;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// tb_clk_div_gen : scoreboard bench for clk_div_gen (4 channels, 8-bit divisors).
// Revision       : 1.0
// ============================================================================
module tb_clk_div_gen;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
`ifdef CLK_DIV_SYNC_LOAD_EN
  localparam bit SYNC_MODE = 1'b1;
`else
  localparam bit SYNC_MODE = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    load;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_en     (en),
    .i_div    (div),
    .i_load   (load),
    .o_clk_out(clk_out),
    .o_tick   (tick)
  );

  // Output level j edges after a channel starts running. fresh=1: started
  // parked with its half-period already in place; fresh=0: started with the
  // reset half-period of 1 and the new one waiting in the shadow register.
  function automatic bit model_out(int j, int h, bit fresh);
    if (j < 0) return 1'b1;
    if (fresh) return (((j + 1) / h) % 2) == 0;
    return ((j / h) % 2) == 1;
  endfunction

  function automatic logic [7:0] model_vec(int j, logic [31:0] divs, logic [3:0] run, bit fresh);
    logic [3:0] o, t;
    int h;
    for (int c = 0; c < NUM_CH; c++) begin
      h = int'(divs[c*DIV_W +: DIV_W]);
      if (h == 0) h = 1;
      if (run[c]) begin
        o[c] = model_out(j, h, fresh);
        t[c] = o[c] & ~model_out(j - 1, h, fresh);
      end else begin
        o[c] = 1'b1;
        t[c] = 1'b0;
      end
    end
    return {o, t};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = '0; load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [31:0] v);
    @(negedge clk);
    load = 1'b1; div = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got, expv;
    rst_n = 1'b0; en = 4'hF; load = 1'b1; div = '1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({4'hF, 4'h0});
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 i, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; en = 4'b0001; load = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp_q.push_back(model_vec(j, 32'h01010101, 4'b0001, SYNC_MODE));
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL reset_default j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
  endtask

  task automatic test_divide();
    logic [7:0]  got, expv;
    logic [31:0] dv = {8'd5, 8'd3, 8'd2, 8'd1};
    do_reset();
    do_load(dv);
    en = 4'hF;
    for (int j = 0; j < 30; j++) begin
      exp_q.push_back(model_vec(j, dv, 4'hF, SYNC_MODE));
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL divide j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid_period();
    logic [7:0]  got, expv;
    logic [31:0] dv = {8'd5, 8'd3, 8'd2, 8'd1};
    do_reset();
    do_load(dv);
    en = 4'hF;
    for (int j = 0; j < 7; j++) begin
      exp_q.push_back(model_vec(j, dv, 4'hF, SYNC_MODE));
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL midrst_run j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
    @(negedge clk);
    rst_n = 1'b0; load = 1'b1; div = {4{8'd9}};
    exp_q.push_back({4'hF, 4'h0});
    @(posedge clk); #1;
    got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL midrst_edge: got out=%b tick=%b, want out=%b tick=%b",
               got[7:4], got[3:0], expv[7:4], expv[3:0]);
    end
    @(negedge clk);
    rst_n = 1'b1; load = 1'b0;
    // The LOAD held during reset must be ignored: divisors return to 1.
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(model_vec(j, 32'h01010101, 4'hF, SYNC_MODE));
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL midrst_after j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
  endtask

  // Channel 0 runs at half-period old_h; a LOAD of new_h arrives at edge load_j.
  task automatic test_load_update(input string name, input int load_j, input int old_h,
                                  input int new_h, input int ncyc);
    logic [7:0] got, expv;
    bit m_out;
    bit m_tick;
    int next_tog;
    int h;
    do_reset();
    do_load({24'h0, 8'(old_h)});
    m_out = 1'b1; next_tog = 0; h = 1;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      en   = 4'b0001;
      load = (j == load_j);
      div  = {24'h0, 8'((j == load_j) ? new_h : old_h)};
      m_tick = 1'b0;
      if (j == next_tog) begin
        m_out  = ~m_out;
        m_tick = m_out;
        h = (j >= load_j) ? new_h : old_h;
        next_tog = j + h;
      end
      exp_q.push_back({3'b111, m_out, 3'b000, m_tick});
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL %s j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 name, j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_sync_load();
    logic [7:0]  got, expv;
    logic [3:0]  o, t, prev;
    logic [31:0] dv = {8'd0, 8'd0, 8'd6, 8'd3};
    do_reset();
    do_load(dv);
    en = 4'b0001;
    repeat (2) @(negedge clk);
    en = 4'b0011;
    repeat (4) @(negedge clk);
    prev = 4'hF;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      load = (j == 0);
      o = {2'b11, ((j / 6) % 2) == 0, ((j / 3) % 2) == 0};
      t = o & ~prev;
      prev = o;
      exp_q.push_back({o, t});
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL sync_load j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_enable_disable();
    logic [7:0]  got, expv;
    logic [31:0] dv = {8'd0, 8'd3, 8'd0, 8'd0};
    int drop_j = SYNC_MODE ? 4 : 7;
    do_reset();
    do_load(dv);
    for (int j = 0; j < drop_j + 3; j++) begin
      @(negedge clk);
      en = (j < drop_j) ? 4'b0100 : 4'b0000;
      exp_q.push_back((j < drop_j) ? model_vec(j, dv, 4'b0100, SYNC_MODE) : {4'hF, 4'h0});
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL disable j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
    // Re-enable; edge 8 is a falling boundary where the disable must win.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      en = (k < 8) ? 4'b0100 : 4'b0000;
      exp_q.push_back((k < 8) ? model_vec(k, dv, 4'b0100, 1'b1) : {4'hF, 4'h0});
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL reenable k=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 k, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0]  got, expv;
    logic [31:0] dv = {8'd0, 8'd2, 8'd0, 8'd1};
    do_reset();
    do_load(dv);
    en = 4'hF;
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back(model_vec(j, dv, 4'hF, SYNC_MODE));
      @(posedge clk); #1;
      got = {clk_out, tick}; expv = exp_q.pop_front(); n_cmp++;
      if (got !== expv) begin
        n_err++;
        $display("FAIL div_zero j=%0d: got out=%b tick=%b, want out=%b tick=%b",
                 j, got[7:4], got[3:0], expv[7:4], expv[3:0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = '0; div = '0; load = 1'b0;
    test_reset();
    test_divide();
    test_reset_mid_period();
`ifndef CLK_DIV_SYNC_LOAD_EN
    test_load_update("glitch_free", 6, 4, 7, 31);
    test_load_update("load_at_boundary", 8, 4, 2, 18);
`else
    test_sync_load();
`endif
    test_enable_disable();
    test_div_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
